poly_eval_ctrl: RTL and testbench
=================================

// Module: poly_eval_ctrl
// PURPOSE
//   Sequencer for a shared signed 20-bit multiply-accumulate datapath. It evaluates
//   result = sum c[i]*x^i using Horner's rule, one MAC step per clock. Coefficients are
//   held in a small internal table that a host programs between runs. The block sits
//   between a host (cfg/start/done) and the signed 20-bit result bus used by the exam
//   datapaths.
// PARAMETERS
//   NCOEF  4   number of coefficients c[0..NCOEF-1]; range 2..8
//   CW     8   coefficient and x width, signed two's complement
//   RW     20  result/accumulator width, signed
// PORTS
//   clk        in   1      system clock; everything updates on the rising edge
//   rst        in   1      asynchronous, active-low reset
//   cfg_we     in   1      coefficient write strobe
//   cfg_addr   in   3      coefficient index; only 0..NCOEF-1 are valid
//   cfg_data   in   CW     coefficient value, signed
//   start      in   1      request to begin an evaluation (level, sampled each edge)
//   x          in   CW     evaluation point, signed; latched when start is accepted
//   busy       out  1      high while an evaluation is in progress
//   done       out  1      one-cycle pulse when result is updated
//   ovf        out  1      saturation occurred during the last run (sticky per run)
//   result     out  RW     signed evaluation result; holds its value between runs
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - state=IDLE; busy=0, done=0, ovf=0, result=0
//     - all coefficients=0, idx=0, acc=0, x_q=0
//   FSM states: IDLE and RUN.
//     IDLE, start=1 at edge E0:
//       - x_q<=x, acc<=0, idx<=NCOEF-1, ovf<=0, busy<=1; go to RUN
//     RUN, each edge:
//       - acc<=sat(acc*x_q + c[idx])
//       - if idx==0: result<=same saturated value, done<=1, busy<=0; go to IDLE
//       - else: idx<=idx-1
//   Latency: start sampled at E0, MAC steps at E1..E_NCOEF.
//     - result/done valid after edge E_NCOEF
//     - done is high for exactly one cycle; in every other cycle done=0
//     - busy is high from after E0 through E_NCOEF
//   Arithmetic:
//     - product acc*x_q is full RW+CW bits; the sum is RW+CW+1 bits
//     - the sum is clamped to [-2^(RW-1), 2^(RW-1)-1] = [-524288, 524287] at default
//     - the clamped value feeds the next step
//     - any clamp sets ovf, which stays 1 until the next accepted start
//   Boundaries:
//     - start while busy: ignored, no restart
//     - start held high: a new run is accepted on the first IDLE edge, i.e. E_NCOEF+1
//     - cfg_we while busy: write dropped, so the table is stable during a run
//     - cfg_we in IDLE with cfg_addr>=NCOEF: ignored
//     - cfg_we and start in the same IDLE edge: the write takes effect and the run
//       uses the new value, because c[NCOEF-1..] is read from E1 onward
//     - rst low mid-run: abort immediately; no done pulse; all state as at reset
//     - x=0: result=c[0]; all coefficients 0: result=0
// TESTING (NCOEF=4, CW=8, RW=20)
//   1. Assert rst=0 with random inputs -> busy=done=ovf=0, result=0; after release,
//      start with x=7 -> result=0.
//   2. Write c3=1, c2=-2, c1=3, c0=-4; start, x=5 -> done 4 cycles after the start
//      edge, result=86, ovf=0, busy high for exactly 4 cycles.
//   3. Write c3=127, others 0; start, x=-128 -> result=-524288, ovf=1. Then start,
//      x=1 -> ovf clears at accept, result=127, ovf=0.
//   4. During a run, pulse start and write c0=99 -> no restart; result unchanged from
//      the original table; the next run also uses the old c0.
//   5. Drive rst=0 on the 2nd RUN cycle -> busy=0 at once, no done pulse, result=0,
//      table cleared; a following run with x=3 gives result=0.
//   6. Hold start=1 continuously, x=0, c0=-9 -> back-to-back runs with no idle gap
//      beyond one cycle; done pulses every 5 cycles; result=-9.

Source files
------------

// File: rtl/poly_eval_if.sv
// Host-side bundle for poly_eval_ctrl: coefficient programming, run handshake and result.
interface poly_eval_if #(
  parameter int CW = 8,
  parameter int RW = 20
);
  logic                 cfg_we;
  logic [2:0]           cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 start;
  logic signed [CW-1:0] x;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic signed [RW-1:0] result;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, x,
    input  busy, done, ovf, result
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, x,
    output busy, done, ovf, result
  );
endinterface

// File: rtl/poly_eval_ctrl.sv
// Horner-rule polynomial evaluator: one saturating MAC step per clock over a
// host-programmed coefficient table, highest coefficient first.
module poly_eval_ctrl #(
  parameter int NCOEF = 4,
  parameter int CW    = 8,
  parameter int RW    = 20
) (
  input  logic         clk,
  input  logic         rst,
  poly_eval_if.slave   bus
);

  localparam int             IW       = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam logic [IW-1:0]  IDX_LAST = IW'(NCOEF - 1);
  localparam logic [3:0]     NCOEF_W  = 4'(NCOEF);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [RW-1:0] acc_q, acc_d;
  logic signed [RW-1:0] result_q, result_d;
  logic signed [CW-1:0] x_q, x_d;
  logic signed [CW-1:0] coef_q [NCOEF];
  logic signed [CW-1:0] coef_d [NCOEF];
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic signed [RW+CW-1:0] prod;
  logic signed [RW+CW:0]   sum;
  logic                    clamp;
  logic signed [RW-1:0]    sat;

  // Full-width product and sum, clamped back to RW bits when the top bits disagree
  always_comb begin
    prod  = (RW+CW)'(acc_q) * (RW+CW)'(x_q);
    sum   = (RW+CW+1)'(prod) + (RW+CW+1)'(coef_q[idx_q]);
    clamp = (sum[RW+CW:RW-1] != {(CW+2){sum[RW-1]}});
    if (!clamp)
      sat = sum[RW-1:0];
    else if (sum[RW+CW])
      sat = {1'b1, {(RW-1){1'b0}}};
    else
      sat = {1'b0, {(RW-1){1'b1}}};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    x_d      = x_q;
    coef_d   = coef_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        // Table writes only land in IDLE so a run always sees a stable table
        if (bus.cfg_we && ({1'b0, bus.cfg_addr} < NCOEF_W))
          coef_d[bus.cfg_addr[IW-1:0]] = bus.cfg_data;
        if (bus.start) begin
          x_d     = bus.x;
          acc_d   = '0;
          idx_d   = IDX_LAST;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = sat;
        ovf_d = ovf_q | clamp;
        if (idx_q == '0) begin
          result_d = sat;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      x_q      <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      x_q      <= x_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      coef_q   <= coef_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_poly_eval_ctrl.sv
// Directed + randomized bench for poly_eval_ctrl against an integer Horner model.
module tb_poly_eval_ctrl;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  poly_eval_if #(.CW(8), .RW(20)) bus ();

  poly_eval_ctrl #(.NCOEF(NC), .CW(8), .RW(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int mc [NC];
  int exp_res;
  bit exp_ovf;

  function automatic void model(input int xv, output int res, output bit ov);
    longint acc = 0;
    ov = 1'b0;
    for (int i = NC - 1; i >= 0; i--) begin
      acc = acc * xv + mc[i];
      if (acc > 524287) begin
        acc = 524287;
        ov  = 1'b1;
      end else if (acc < -524288) begin
        acc = -524288;
        ov  = 1'b1;
      end
    end
    res = int'(acc);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(addr);
    bus.cfg_data = 8'(val);
    step();
    bus.cfg_we = 1'b0;
    if (addr < NC) mc[addr] = val;
  endtask

  task automatic run_eval(input string tag, input int xv, input bit disturb,
                          input bit pre_we, input int pre_addr, input int pre_val);
    int n, busy_cnt;
    bit got;
    if (pre_we) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(pre_addr);
      bus.cfg_data = 8'(pre_val);
      if (pre_addr < NC) mc[pre_addr] = pre_val;
    end
    model(xv, exp_res, exp_ovf);
    bus.start = 1'b1;
    bus.x     = 8'(xv);
    step();
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    bus.x      = 8'($urandom);
    chk({tag, "_busy_at_accept"}, bus.busy, 1);
    chk({tag, "_ovf_cleared"}, bus.ovf, 0);
    busy_cnt = 1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      if (bus.done) got = 1'b1;
      else if (bus.busy) busy_cnt++;
      if (disturb && n == 1) begin
        bus.start    = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = 8'sd99;
      end
    end
    chk({tag, "_latency"}, n, NC);
    chk({tag, "_busy_cycles"}, busy_cnt, NC);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_ovf"}, bus.ovf, 32'(exp_ovf));
    step();
    chk({tag, "_done_single"}, bus.done, 0);
    chk({tag, "_no_restart"}, bus.busy, 0);
  endtask

  initial begin
    int pulses, last, cyc, v, xv;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.x = '0;
    for (int i = 0; i < NC; i++) mc[i] = 0;

    // Reset held with random input activity
    for (int i = 0; i < 4; i++) begin
      bus.cfg_we = 1'($urandom); bus.cfg_addr = 3'($urandom);
      bus.cfg_data = 8'($urandom); bus.start = 1'($urandom); bus.x = 8'($urandom);
      step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_result", bus.result, 0);
    end
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    rst = 1'b1;
    step();
    run_eval("t1_zero_table", 7, 0, 0, 0, 0);

    write_coef(3, 1); write_coef(2, -2); write_coef(1, 3); write_coef(0, -4);
    run_eval("t2_basic", 5, 0, 0, 0, 0);

    write_coef(3, 127); write_coef(2, 0); write_coef(1, 0); write_coef(0, 0);
    run_eval("t3_sat", -128, 0, 0, 0, 0);
    run_eval("t3_recover", 1, 0, 0, 0, 0);

    write_coef(3, -5); write_coef(2, 17); write_coef(1, -33); write_coef(0, 12);
    write_coef(6, 55);
    run_eval("t4_disturb", 3, 1, 0, 0, 0);
    run_eval("t4_old_c0", -2, 0, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      for (int a = 0; a < NC; a++) begin
        v = int'($urandom_range(0, 255)) - 128;
        write_coef(a, v);
      end
      if ($urandom_range(0, 2) == 0) write_coef(int'($urandom_range(4, 7)), 77);
      xv = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) xv = 0;
      v = int'($urandom_range(0, 255)) - 128;
      run_eval("rand", xv, 1'($urandom), ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 7)), v);
    end

    // Abort on the second RUN cycle
    bus.start = 1'b1; bus.x = 8'sd5;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_result", bus.result, 0);
    chk("t5_ovf", bus.ovf, 0);
    step(); step();
    chk("t5_no_done", bus.done, 0);
    rst = 1'b1;
    for (int i = 0; i < NC; i++) mc[i] = 0;
    step();
    run_eval("t5_cleared", 3, 0, 0, 0, 0);

    // Back-to-back runs with start held
    write_coef(0, -9);
    bus.x = 8'sd0; bus.start = 1'b1;
    pulses = 0; last = 0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      step();
      if (bus.done) begin
        chk("t6_result", bus.result, -9);
        if (pulses > 0) chk("t6_gap", cyc - last, 5);
        else chk("t6_first", cyc, 5);
        last = cyc;
        pulses++;
      end
    end
    chk("t6_pulses", pulses, 6);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 10) begin
      step();
      cyc++;
    end
    chk("t6_drain", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
